spike_classifier: RTL and testbench
===================================

# spike_classifier

Parametrised output-layer decision unit for the spiking ECG network. It takes one spike bit per output neuron each network timestep and accumulates a saturating spike count per class over a bounded window. It decides a class either at first-to-threshold or at window expiry, then reports the result with a valid/done handshake. It sits between the last neuron layer and the top-level controller; `busy` replaces the old end-of-process signal.

## Interface
- NUM_NEURONS, 6, output neurons; neuron i belongs to class (i mod NUM_CLASSES)+1
- NUM_CLASSES, 3, classes; code 0 means "no decision"
- CLASS_W, 2, class_out width; must satisfy 2^CLASS_W > NUM_CLASSES
- WINDOW, 300, timesteps per classification window (>=1)
- CNT_W, 9, per-class counter and step-counter width; must hold WINDOW
- THRESH, 1, spike count that triggers an early decision (1..2^CNT_W-1)

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request to begin a window
- step_en  in  1  network timestep strobe; spikes sampled only when high
- spikes_in  in  NUM_NEURONS  spike bits for the current timestep
- busy  out  1  window in progress
- done  out  1  one-cycle pulse when a decision is made
- valid  out  1  class_out holds a decision (level)
- timed_out  out  1  decision was made at window expiry, not by threshold
- class_out  out  CLASS_W  decided class, 0 = none

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start: clear all class counters, load steps_left=WINDOW, clear valid, clear timed_out, go to RUN.
- start in RUN is ignored; no abort.
- RUN + step_en: per class c, inc_c = popcount of that class's neuron spikes; cnt_c_next = min(cnt_c + inc_c, 2^CNT_W-1); steps_left decrements.
- Early decision: if any cnt_c_next >= THRESH, pick the lowest-indexed such class; timed_out=0; go to DONE.
- Expiry: if no threshold hit and steps_left==1 on this step, go to DONE with timed_out=1; class chosen per Configuration.
- Threshold takes priority over expiry on the same step.
- RUN without step_en: hold all state.
- DONE: valid=1, class_out held until the next accepted start or reset.

## Timing
- Reset (resetn=0 at clk edge): state IDLE, counters 0, steps_left 0; busy=0, done=0, valid=0, timed_out=0, class_out=0. Reset mid-window discards the window.
- start accepted at edge t: busy=1 from t+1.
- The first step_en sampled is at edge t+1 or later; a step_en coincident with start is not counted.
- Decision on step edge d: class_out, valid, timed_out and done all asserted from d+1. done lasts exactly one cycle and busy=0 from d+1.
- Worst-case latency: WINDOW step_en pulses after start.
- start in DONE at edge s: valid=0, class_out=0 from s+1.

## Configuration
- SPIKE_CLASSIFIER_MAJORITY_EN defined: on expiry, class_out is the class with the largest count; ties go to the lowest index; all-zero counts give 0.
- SPIKE_CLASSIFIER_MAJORITY_EN undefined: on expiry, class_out=0 always and the argmax logic is not built.

## Structure
- Package spike_cls_pkg: state enum (IDLE, RUN, DONE), clog2-based width helper, NO_CLASS constant = 0.
- Sub-module spike_argmax: combinational max/lowest-index-tie selector over NUM_CLASSES counts. It is instantiated only under SPIKE_CLASSIFIER_MAJORITY_EN.

## Test plan
- Defaults, start, then spikes_in=6'b000010 on the first step -> class_out=2, valid=1, timed_out=0, done pulse 1 cycle after that step.
- Defaults, spikes_in=6'b100001 on one step -> both class 1 and class 3 hit threshold; class_out=1 (lowest index).
- THRESH=5, WINDOW=4, MAJORITY on: class 3 spikes twice, class 2 once, then silence -> after the 4th step, class_out=3, timed_out=1.
- Same stimulus, macro off -> class_out=0, timed_out=1, valid=1.
- resetn=0 mid-window, then start, then 300 silent steps -> class_out=0, timed_out=1; all outputs 0 during reset.
- start pulsed during RUN, and step_en held low for 50 cycles -> no restart, no state change, window length still WINDOW steps.

Source files
------------

// File: rtl/spike_cls_pkg.sv
// -----------------------------------------------------------------------------
// spike_cls_pkg
// Shared definitions for the spike classifier output stage.
//   state_t    : window FSM states (IDLE, RUN, DONE)
//   NO_CLASS   : class code meaning "no decision"
//   width_for  : bits needed to hold the value max_val (at least 1)
// No ports; imported by spike_classifier and spike_argmax.
// -----------------------------------------------------------------------------
package spike_cls_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NO_CLASS = 0;

   function automatic int width_for(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/spike_argmax.sv
// -----------------------------------------------------------------------------
// spike_argmax
// Combinational selector returning the 1-based index of the largest class
// count. Ties resolve to the lowest class index; all-zero counts give NO_CLASS.
// Only compiled when SPIKE_CLASSIFIER_MAJORITY_EN is defined, so the default
// build carries no argmax logic at all.
// Ports:
//   counts    in  NUM_CLASSES*CNT_W  packed counts, class 1 in the LSBs
//   class_sel out CLASS_W            selected class code (0 = none)
// -----------------------------------------------------------------------------
`ifdef SPIKE_CLASSIFIER_MAJORITY_EN
module spike_argmax
   import spike_cls_pkg::*;
#(
   parameter int NUM_CLASSES = 3,
   parameter int CNT_W       = 9,
   parameter int CLASS_W     = 2
) (
   input  logic [NUM_CLASSES*CNT_W-1:0] counts,
   output logic [CLASS_W-1:0]           class_sel
);

   logic [CNT_W-1:0]   best_val_s;
   logic [CLASS_W-1:0] best_cls_s;

   // Linear scan; strict '>' keeps the earliest class on ties and leaves
   // NO_CLASS selected when every count is zero.
   always_comb begin
      best_val_s = {CNT_W{1'b0}};
      best_cls_s = CLASS_W'(NO_CLASS);
      for (int c = 0; c < NUM_CLASSES; c++) begin
         best_cls_s = (counts[c*CNT_W +: CNT_W] > best_val_s) ? CLASS_W'(c + 1) : best_cls_s;
         best_val_s = (counts[c*CNT_W +: CNT_W] > best_val_s) ? counts[c*CNT_W +: CNT_W] : best_val_s;
      end
   end

   assign class_sel = best_cls_s;

endmodule
`endif

// File: rtl/spike_classifier.sv
// -----------------------------------------------------------------------------
// spike_classifier
// Output-layer decision unit: accumulates saturating per-class spike counts
// over a window of network timesteps and decides a class either when a count
// first reaches THRESH or when the window expires.
// Optional feature macro: SPIKE_CLASSIFIER_MAJORITY_EN -- when defined, an
// expired window reports the majority (argmax) class instead of 0.
// Ports:
//   clk        in   clock
//   resetn     in   synchronous active-low reset
//   start      in   begin a window (ignored while a window runs)
//   step_en    in   timestep strobe; spikes_in sampled only when high
//   spikes_in  in   one spike bit per output neuron
//   busy       out  window in progress
//   done       out  one-cycle pulse on decision
//   valid      out  class_out holds a decision
//   timed_out  out  decision came from window expiry
//   class_out  out  decided class, 0 = none
// -----------------------------------------------------------------------------
module spike_classifier
   import spike_cls_pkg::*;
#(
   parameter int NUM_NEURONS = 6,
   parameter int NUM_CLASSES = 3,
   parameter int CLASS_W     = 2,
   parameter int WINDOW      = 300,
   parameter int CNT_W       = 9,
   parameter int THRESH      = 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic                   step_en,
   input  logic [NUM_NEURONS-1:0] spikes_in,
   output logic                   busy,
   output logic                   done,
   output logic                   valid,
   output logic                   timed_out,
   output logic [CLASS_W-1:0]     class_out
);

   localparam int               INC_W      = width_for(NUM_NEURONS);
   localparam logic [CNT_W:0]   CNT_MAX_C  = {1'b0, {CNT_W{1'b1}}};
   localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] WINDOW_C   = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r [NUM_CLASSES];
   logic [CNT_W-1:0]   steps_left_r;
   logic               busy_r;
   logic               done_r;
   logic               valid_r;
   logic               timed_out_r;
   logic [CLASS_W-1:0] class_r;

   logic [INC_W-1:0]   inc_s      [NUM_CLASSES];
   logic [CNT_W:0]     sum_s      [NUM_CLASSES];
   logic [CNT_W-1:0]   cnt_next_s [NUM_CLASSES];
   logic               hit_s;
   logic [CLASS_W-1:0] hit_cls_s;
   logic [CLASS_W-1:0] expiry_cls_s;

   // Per-class popcount of this timestep's spikes (neuron i -> class i mod N).
   always_comb begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
         inc_s[c] = {INC_W{1'b0}};
         for (int i = 0; i < NUM_NEURONS; i++) begin
            inc_s[c] = inc_s[c] + (((i % NUM_CLASSES) == c) ? INC_W'(spikes_in[i]) : {INC_W{1'b0}});
         end
      end
   end

   // Saturating next counts; one extra bit on the sum detects overflow.
   always_comb begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
         sum_s[c]      = {1'b0, cnt_r[c]} + (CNT_W+1)'(inc_s[c]);
         cnt_next_s[c] = (sum_s[c] > CNT_MAX_C) ? {CNT_W{1'b1}} : sum_s[c][CNT_W-1:0];
      end
   end

   // Threshold search runs from the top class down so the lowest index wins.
   always_comb begin
      hit_s     = 1'b0;
      hit_cls_s = CLASS_W'(NO_CLASS);
      for (int c = NUM_CLASSES - 1; c >= 0; c--) begin
         hit_cls_s = (cnt_next_s[c] >= THRESH_C) ? CLASS_W'(c + 1) : hit_cls_s;
         hit_s     = hit_s | (cnt_next_s[c] >= THRESH_C);
      end
   end

`ifdef SPIKE_CLASSIFIER_MAJORITY_EN
   logic [NUM_CLASSES*CNT_W-1:0] counts_flat_s;

   // Pack the post-step counts for the argmax selector.
   always_comb begin
      counts_flat_s = {(NUM_CLASSES*CNT_W){1'b0}};
      for (int c = 0; c < NUM_CLASSES; c++) begin
         counts_flat_s[c*CNT_W +: CNT_W] = cnt_next_s[c];
      end
   end

   spike_argmax #(
      .NUM_CLASSES (NUM_CLASSES),
      .CNT_W       (CNT_W),
      .CLASS_W     (CLASS_W)
   ) u_argmax (
      .counts    (counts_flat_s),
      .class_sel (expiry_cls_s)
   );
`else
   // Without majority voting an expired window reports no class.
   assign expiry_cls_s = CLASS_W'(NO_CLASS);
`endif

   // Window FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r      <= IDLE;
         steps_left_r <= {CNT_W{1'b0}};
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         valid_r      <= 1'b0;
         timed_out_r  <= 1'b0;
         class_r      <= CLASS_W'(NO_CLASS);
         for (int c = 0; c < NUM_CLASSES; c++) begin
            cnt_r[c] <= {CNT_W{1'b0}};
         end
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  for (int c = 0; c < NUM_CLASSES; c++) begin
                     cnt_r[c] <= {CNT_W{1'b0}};
                  end
                  steps_left_r <= WINDOW_C;
                  busy_r       <= 1'b1;
                  valid_r      <= 1'b0;
                  timed_out_r  <= 1'b0;
                  class_r      <= CLASS_W'(NO_CLASS);
                  state_r      <= RUN;
               end else begin
                  state_r <= state_r;
               end
            end
            RUN: begin
               if (step_en) begin
                  for (int c = 0; c < NUM_CLASSES; c++) begin
                     cnt_r[c] <= cnt_next_s[c];
                  end
                  steps_left_r <= steps_left_r - ONE_C;
                  if (hit_s) begin
                     class_r     <= hit_cls_s;
                     timed_out_r <= 1'b0;
                     valid_r     <= 1'b1;
                     done_r      <= 1'b1;
                     busy_r      <= 1'b0;
                     state_r     <= DONE;
                  end else if (steps_left_r == ONE_C) begin
                     class_r     <= expiry_cls_s;
                     timed_out_r <= 1'b1;
                     valid_r     <= 1'b1;
                     done_r      <= 1'b1;
                     busy_r      <= 1'b0;
                     state_r     <= DONE;
                  end else begin
                     state_r <= RUN;
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign valid     = valid_r;
   assign timed_out = timed_out_r;
   assign class_out = class_r;

endmodule

// File: tb/tb_spike_classifier.sv
// -----------------------------------------------------------------------------
// tb_spike_classifier
// Self-checking bench. dut uses default parameters and is checked against a
// behavioural window model; dut2 (THRESH=5, WINDOW=4) exercises expiry class
// selection with and without SPIKE_CLASSIFIER_MAJORITY_EN.
// -----------------------------------------------------------------------------
module tb_spike_classifier;

   localparam int WIN = 300;
   localparam int CMAX = 511;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start, step_en;
   logic [5:0] spikes_in;
   logic       busy, done, valid, timed_out;
   logic [1:0] class_out;

   logic       start2, step_en2;
   logic [5:0] spikes2;
   logic       busy2, done2, valid2, timed_out2;
   logic [1:0] class2;

   int n_pass = 0;
   int n_total = 0;

   // behavioural model of dut
   bit         m_busy, m_done, m_valid, m_to;
   logic [1:0] m_cls;
   int         m_cnt [3];
   int         m_left;

   always #5 clk = ~clk;

   spike_classifier dut (
      .clk(clk), .resetn(resetn), .start(start), .step_en(step_en),
      .spikes_in(spikes_in), .busy(busy), .done(done), .valid(valid),
      .timed_out(timed_out), .class_out(class_out)
   );

   spike_classifier #(
      .NUM_NEURONS(6), .NUM_CLASSES(3), .CLASS_W(2),
      .WINDOW(4), .CNT_W(9), .THRESH(5)
   ) dut2 (
      .clk(clk), .resetn(resetn), .start(start2), .step_en(step_en2),
      .spikes_in(spikes2), .busy(busy2), .done(done2), .valid(valid2),
      .timed_out(timed_out2), .class_out(class2)
   );

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_valid = 0; m_to = 0; m_cls = 2'd0;
      m_left = 0;
      for (int c = 0; c < 3; c++) m_cnt[c] = 0;
   endtask

   // Apply one edge of the spec's window rules to the model.
   task automatic model_step(input bit s, input bit e, input logic [5:0] sp);
      int first;
      m_done = 0;
      if (!m_busy) begin
         if (s) begin
            m_busy = 1; m_valid = 0; m_to = 0; m_cls = 2'd0; m_left = WIN;
            for (int c = 0; c < 3; c++) m_cnt[c] = 0;
         end
      end else if (e) begin
         for (int i = 0; i < 6; i++) m_cnt[i % 3] += int'(sp[i]);
         for (int c = 0; c < 3; c++) if (m_cnt[c] > CMAX) m_cnt[c] = CMAX;
         m_left--;
         first = 0;
         for (int c = 2; c >= 0; c--) if (m_cnt[c] >= 1) first = c + 1;
         if (first != 0) begin
            m_busy = 0; m_done = 1; m_valid = 1; m_to = 0; m_cls = 2'(first);
         end else if (m_left == 0) begin
            // all counts are zero here, so majority mode also yields 0
            m_busy = 0; m_done = 1; m_valid = 1; m_to = 1; m_cls = 2'd0;
         end
      end
   endtask

   // Drive dut for one clock edge and advance the model.
   task automatic cycle(input bit s, input bit e, input logic [5:0] sp);
      start = s; step_en = e; spikes_in = sp;
      @(posedge clk);
      #1;
      if (!resetn) model_reset();
      else model_step(s, e, sp);
      start = 1'b0; step_en = 1'b0; spikes_in = 6'd0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start = 1'b0; step_en = 1'b0; spikes_in = 6'd0;
      start2 = 1'b0; step_en2 = 1'b0; spikes2 = 6'd0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      n_total++;
      if ({busy, done, valid, timed_out, class_out} !== 6'd0) begin
         $display("FAIL reset_dut: got %b exp %b", {busy, done, valid, timed_out, class_out}, 6'd0);
      end else n_pass++;
      n_total++;
      if ({busy2, done2, valid2, timed_out2, class2} !== 6'd0) begin
         $display("FAIL reset_dut2: got %b exp %b", {busy2, done2, valid2, timed_out2, class2}, 6'd0);
      end else n_pass++;
      resetn = 1'b1;
   endtask

   task automatic test_single_spike();
      cycle(1'b1, 1'b0, 6'd0);
      n_total++;
      if (busy !== 1'b1) $display("FAIL single_busy: got %b exp 1", busy);
      else n_pass++;
      cycle(1'b0, 1'b1, 6'b000010);
      n_total++;
      if ({busy, done, valid, timed_out, class_out} !== {1'b0, 1'b1, 1'b1, 1'b0, 2'd2}) begin
         $display("FAIL single_decide: got %b exp %b", {busy, done, valid, timed_out, class_out}, {1'b0, 1'b1, 1'b1, 1'b0, 2'd2});
      end else n_pass++;
      cycle(1'b0, 1'b0, 6'd0);
      n_total++;
      if ({done, valid, class_out} !== {1'b0, 1'b1, 2'd2}) begin
         $display("FAIL single_hold: got %b exp %b", {done, valid, class_out}, {1'b0, 1'b1, 2'd2});
      end else n_pass++;
   endtask

   task automatic test_tie_lowest();
      cycle(1'b1, 1'b0, 6'd0);
      n_total++;
      if ({busy, valid, class_out} !== {1'b1, 1'b0, 2'd0}) begin
         $display("FAIL restart_clear: got %b exp %b", {busy, valid, class_out}, {1'b1, 1'b0, 2'd0});
      end else n_pass++;
      cycle(1'b0, 1'b1, 6'b100001);
      n_total++;
      if ({done, valid, timed_out, class_out} !== {1'b1, 1'b1, 1'b0, 2'd1}) begin
         $display("FAIL tie_lowest: got %b exp %b", {done, valid, timed_out, class_out}, {1'b1, 1'b1, 1'b0, 2'd1});
      end else n_pass++;
   endtask

   task automatic test_random();
      logic [5:0] sp;
      bit s, e;
      for (int w = 0; w < 6; w++) begin
         cycle(1'b1, 1'b0, 6'd0);
         for (int k = 0; k < 700 && m_busy; k++) begin
            e  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 29) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            cycle(s, e, sp);
            n_total++;
            if ({busy, done, valid, timed_out, class_out} !== {m_busy, m_done, m_valid, m_to, m_cls}) begin
               $display("FAIL random_w%0d_k%0d: got %b exp %b", w, k,
                        {busy, done, valid, timed_out, class_out}, {m_busy, m_done, m_valid, m_to, m_cls});
            end else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_window();
      int bad;
      cycle(1'b1, 1'b0, 6'd0);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 6'd0);
      resetn = 1'b0;
      cycle(1'b0, 1'b1, 6'b111111);
      n_total++;
      if ({busy, done, valid, timed_out, class_out} !== 6'd0) begin
         $display("FAIL midreset_zero: got %b exp %b", {busy, done, valid, timed_out, class_out}, 6'd0);
      end else n_pass++;
      resetn = 1'b1;
      cycle(1'b1, 1'b0, 6'd0);
      bad = 0;
      for (int k = 0; k < WIN - 1; k++) begin
         cycle(1'b0, 1'b1, 6'd0);
         if ({busy, done, valid} !== 3'b100) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL silent_window_early: got %0d bad cycles exp 0", bad);
      else n_pass++;
      cycle(1'b0, 1'b1, 6'd0);
      n_total++;
      if ({busy, done, valid, timed_out, class_out} !== {1'b0, 1'b1, 1'b1, 1'b1, 2'd0}) begin
         $display("FAIL silent_expiry: got %b exp %b", {busy, done, valid, timed_out, class_out}, {1'b0, 1'b1, 1'b1, 1'b1, 2'd0});
      end else n_pass++;
   endtask

   task automatic test_start_in_run_hold();
      int bad;
      cycle(1'b1, 1'b0, 6'd0);
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 6'd0);
      bad = 0;
      cycle(1'b1, 1'b0, 6'd0);
      for (int k = 0; k < 50; k++) begin
         cycle(1'b0, 1'b0, 6'b111111);
         if ({busy, done, valid} !== 3'b100) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL run_hold: got %0d bad cycles exp 0", bad);
      else n_pass++;
      bad = 0;
      for (int k = 0; k < WIN - 11; k++) begin
         cycle(1'b0, 1'b1, 6'd0);
         if ({busy, done} !== 2'b10) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL run_no_restart: got %0d bad cycles exp 0", bad);
      else n_pass++;
      cycle(1'b0, 1'b1, 6'd0);
      n_total++;
      if ({busy, done, valid, timed_out, class_out} !== {m_busy, m_done, m_valid, m_to, m_cls}
          || m_done !== 1'b1) begin
         $display("FAIL run_window_len: got %b exp %b", {busy, done, valid, timed_out, class_out}, {1'b0, 1'b1, 1'b1, 1'b1, 2'd0});
      end else n_pass++;
   endtask

   task automatic test_majority();
      logic [5:0] seq [4];
      logic [1:0] exp_cls;
`ifdef SPIKE_CLASSIFIER_MAJORITY_EN
      exp_cls = 2'd3;
`else
      exp_cls = 2'd0;
`endif
      seq[0] = 6'b000100;  // neuron 2 -> class 3
      seq[1] = 6'b100000;  // neuron 5 -> class 3
      seq[2] = 6'b000010;  // neuron 1 -> class 2
      seq[3] = 6'b000000;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step_en2 = 1'b1; spikes2 = seq[k];
         @(posedge clk); #1;
         step_en2 = 1'b0; spikes2 = 6'd0;
         if (k == 2) begin
            n_total++;
            if ({busy2, done2, valid2} !== 3'b100) begin
               $display("FAIL maj_pending: got %b exp %b", {busy2, done2, valid2}, 3'b100);
            end else n_pass++;
         end
      end
      n_total++;
      if ({busy2, done2, valid2, timed_out2, class2} !== {1'b0, 1'b1, 1'b1, 1'b1, exp_cls}) begin
         $display("FAIL maj_expiry: got %b exp %b", {busy2, done2, valid2, timed_out2, class2}, {1'b0, 1'b1, 1'b1, 1'b1, exp_cls});
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 1'b0, 6'd0);
      cycle(1'b0, 1'b1, 6'b001000);
      n_total++;
      if ({done, class_out} !== {1'b1, 2'd1}) begin
         $display("FAIL b2b_first: got %b exp %b", {done, class_out}, {1'b1, 2'd1});
      end else n_pass++;
      cycle(1'b1, 1'b0, 6'd0);
      n_total++;
      if ({busy, done, valid, timed_out, class_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         $display("FAIL b2b_clear: got %b exp %b", {busy, done, valid, timed_out, class_out}, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
      end else n_pass++;
      cycle(1'b0, 1'b1, 6'b010000);
      n_total++;
      if ({busy, done, valid, timed_out, class_out} !== {1'b0, 1'b1, 1'b1, 1'b0, 2'd2}) begin
         $display("FAIL b2b_second: got %b exp %b", {busy, done, valid, timed_out, class_out}, {1'b0, 1'b1, 1'b1, 1'b0, 2'd2});
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_spike();
      test_tie_lowest();
      test_random();
      test_reset_mid_window();
      test_start_in_run_hold();
      test_majority();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
